// File: rtl/wave_analyzer_pkg.sv
// Shared types and constants for the wave_analyzer block.
// Holds the sample width, FSM state encoding and saturation helpers.
package wave_pkg;

   localparam int SAMPLE_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MINMAX = 2'd1,
      PERIOD = 2'd2,
      DONE   = 2'd3
   } wa_state_t;

   localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 8'hFF;
   localparam logic [7:0]          CROSS_SAT  = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == CROSS_SAT) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/wave_analyzer_if.sv
// Sample stream input and result readback bundle for wave_analyzer.
// master drives samples and start; slave (the analyzer) drives results.
interface wave_analyzer_if
   import wave_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   logic                start;
   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample;
   logic                busy;
   logic                done;
   logic [SAMPLE_W-1:0] min_val;
   logic [SAMPLE_W-1:0] max_val;
   logic [SAMPLE_W-1:0] p2p;
   logic [7:0]          crossings;
   logic [CNT_W-1:0]    period;

   modport master (
      output start, sample_valid, sample,
      input  busy, done, min_val, max_val, p2p, crossings, period
   );

   modport slave (
      input  start, sample_valid, sample,
      output busy, done, min_val, max_val, p2p, crossings, period
   );

endinterface

// File: rtl/wave_analyzer_cross_det.sv
// Rising midpoint crossing detector; fire is combinational on the current valid sample.
// No backpressure: en qualifies samples; WAVE_HYST_EN selects the armed hysteresis detector.
module wave_cross_det
   import wave_pkg::*;
#(
   parameter int HYST = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [SAMPLE_W-1:0] mid,
   output logic                fire
);

`ifdef WAVE_HYST_EN
   logic                armed;
   logic [SAMPLE_W:0]   lo_wide;
   logic [SAMPLE_W:0]   hi_wide;
   logic [SAMPLE_W-1:0] lo_th;
   logic [SAMPLE_W-1:0] hi_th;

   // Bit SAMPLE_W flags borrow/carry out of the 8-bit range, which clamps the threshold.
   always_comb begin
      lo_wide = {1'b0, mid} - (SAMPLE_W+1)'(HYST);
      hi_wide = {1'b0, mid} + (SAMPLE_W+1)'(HYST);
      lo_th   = lo_wide[SAMPLE_W] ? '0 : lo_wide[SAMPLE_W-1:0];
      hi_th   = hi_wide[SAMPLE_W] ? SAMPLE_MAX : hi_wide[SAMPLE_W-1:0];
      fire    = en && armed && (sample >= hi_th);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
      end else if (clear) begin
         armed <= 1'b0;
      end else if (en) begin
         if (fire) begin
            armed <= 1'b0;
         end else if (sample < lo_th) begin
            armed <= 1'b1;
         end
      end
   end
`else
   logic [SAMPLE_W-1:0] prev;
   logic                have_prev;

   // have_prev keeps the first sample of a pass from ever counting.
   assign fire = en && have_prev && (prev < mid) && (sample >= mid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev      <= '0;
         have_prev <= 1'b0;
      end else if (clear) begin
         have_prev <= 1'b0;
      end else if (en) begin
         prev      <= sample;
         have_prev <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/wave_analyzer.sv
// Two-pass windowed min/max then crossing/period measurement (WAVE_HYST_EN adds hysteresis).
// Latency: done 2N+1 cycles after start with valid held high; invalid samples stall the passes.
module wave_analyzer
   import wave_pkg::*;
#(
   parameter int WIN_LOG2 = 8,
   parameter int CNT_W    = 16,
   parameter int HYST     = 4
) (
   input  logic          clk,
   input  logic          rst,
   wave_analyzer_if.slave bus
);

   localparam int                N_WIN     = 1 << WIN_LOG2;
   localparam logic [WIN_LOG2:0] CNT_LAST  = (WIN_LOG2+1)'(N_WIN - 1);
   localparam logic [WIN_LOG2:0] CNT_FULL  = (WIN_LOG2+1)'(N_WIN);

   wa_state_t           state;
   wa_state_t           state_next;
   logic [WIN_LOG2:0]   cnt;
   logic [SAMPLE_W-1:0] run_min;
   logic [SAMPLE_W-1:0] run_max;
   logic [SAMPLE_W:0]   mid_sum;
   logic [SAMPLE_W-1:0] mid;
   logic [7:0]          cross_cnt;
   logic [CNT_W-1:0]    per_cnt;
   logic [CNT_W-1:0]    per_inc;
   logic [CNT_W-1:0]    per_hold;
   logic                seen_cross;
   logic                start_go;
   logic                mm_take;
   logic                p_take;
   logic                fire;

   logic [SAMPLE_W-1:0] min_r;
   logic [SAMPLE_W-1:0] max_r;
   logic [SAMPLE_W-1:0] p2p_r;
   logic [7:0]          cross_r;
   logic [CNT_W-1:0]    period_r;

   assign start_go = (state == IDLE) && bus.start;
   assign mm_take  = (state == MINMAX) && bus.sample_valid;
   // PERIOD holds one extra cycle at CNT_FULL so the last crossing settles before capture.
   assign p_take   = (state == PERIOD) && bus.sample_valid && (cnt != CNT_FULL);

   // min/max are frozen throughout PERIOD, so the midpoint is stable for the whole pass.
   assign mid_sum  = {1'b0, run_min} + {1'b0, run_max};
   assign mid      = mid_sum[SAMPLE_W:1];

   assign per_inc  = (per_cnt == {CNT_W{1'b1}}) ? per_cnt : per_cnt + CNT_W'(1);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = MINMAX;
         MINMAX:  if (bus.sample_valid && (cnt == CNT_LAST)) state_next = PERIOD;
         PERIOD:  if (cnt == CNT_FULL) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            cnt <= '0;
         end else if (mm_take || p_take) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   wave_cross_det #(
      .HYST (HYST)
   ) u_cross_det (
      .clk    (clk),
      .rst    (rst),
      .clear  (state != PERIOD),
      .en     (p_take),
      .sample (bus.sample),
      .mid    (mid),
      .fire   (fire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_min    <= '0;
         run_max    <= '0;
         cross_cnt  <= '0;
         per_cnt    <= '0;
         per_hold   <= '0;
         seen_cross <= 1'b0;
      end else if (start_go) begin
         run_min    <= SAMPLE_MAX;
         run_max    <= '0;
         cross_cnt  <= '0;
         per_cnt    <= '0;
         per_hold   <= '0;
         seen_cross <= 1'b0;
      end else begin
         if (mm_take) begin
            if (bus.sample < run_min) run_min <= bus.sample;
            if (bus.sample > run_max) run_max <= bus.sample;
         end
         // The first crossing only starts the period counter; later ones close an interval.
         if (fire) begin
            cross_cnt  <= sat_inc8(cross_cnt);
            seen_cross <= 1'b1;
            per_cnt    <= '0;
            if (seen_cross) per_hold <= per_inc;
         end else if (p_take && seen_cross) begin
            per_cnt <= per_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_r    <= '0;
         max_r    <= '0;
         p2p_r    <= '0;
         cross_r  <= '0;
         period_r <= '0;
      end else if ((state == PERIOD) && (state_next == DONE)) begin
         min_r    <= run_min;
         max_r    <= run_max;
         p2p_r    <= run_max - run_min;
         cross_r  <= cross_cnt;
         period_r <= per_hold;
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.min_val   = min_r;
   assign bus.max_val   = max_r;
   assign bus.p2p       = p2p_r;
   assign bus.crossings = cross_r;
   assign bus.period    = period_r;

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed self-checking bench for wave_analyzer with N=256.
// Expected values are hand-derived from the stimulus patterns.
module tb_wave_analyzer;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   wave_analyzer_if #(.CNT_W(16)) bus ();

   wave_analyzer #(
      .WIN_LOG2 (8),
      .CNT_W    (16),
      .HYST     (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // 0 square 64x00/64xFF, 1 sawtooth, 2 constant 0x80, 3 square window then 7E/81 alternation
   function automatic logic [7:0] samp(input int pat, input int idx);
      logic [7:0] sq;
      sq = (((idx / 64) % 2) == 1) ? 8'hFF : 8'h00;
      case (pat)
         0:       return sq;
         1:       return 8'(idx % 256);
         2:       return 8'h80;
         default: return (idx < 256) ? sq : (((idx % 2) == 1) ? 8'h81 : 8'h7E);
      endcase
   endfunction

   // Called #1 after an edge; the next edge is the start edge k. done_at is cycles after k.
   task automatic run_meas(input int pat, input bit tog, input bit poke, input int abort_at,
                           output int done_at, output bit busy_done, output bit busy_first);
      int idx;
      bit v;
      done_at    = -1;
      busy_done  = 1'b0;
      busy_first = 1'b0;
      idx = 0;
      bus.start        = 1'b1;
      bus.sample_valid = 1'b1;
      bus.sample       = 8'h00;
      @(posedge clk); #1;
      busy_first       = bus.busy;
      bus.start        = 1'b0;
      v                = !tog;
      bus.sample_valid = v;
      bus.sample       = samp(pat, idx);
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(posedge clk); #1;
         if (v) idx++;
         if (abort_at != 0 && cyc == abort_at) begin
            rst = 1'b1;
            #1;
            break;
         end
         if (bus.done) begin
            done_at   = cyc;
            busy_done = bus.busy;
            break;
         end
         v                = tog ? !v : 1'b1;
         bus.sample_valid = v;
         bus.sample       = samp(pat, idx);
         bus.start        = poke && ((cyc % 37) == 5);
      end
      bus.start        = 1'b0;
      bus.sample_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0; bus.sample_valid = 1'b0; bus.sample = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b exp 0", bus.done); end
      tests++; if (bus.min_val !== 8'h00) begin fails++; $display("FAIL reset_min got %h exp 00", bus.min_val); end
      tests++; if (bus.max_val !== 8'h00) begin fails++; $display("FAIL reset_max got %h exp 00", bus.max_val); end
      tests++; if (bus.p2p !== 8'h00) begin fails++; $display("FAIL reset_p2p got %h exp 00", bus.p2p); end
      tests++; if (bus.crossings !== 8'h00) begin fails++; $display("FAIL reset_cross got %0d exp 0", bus.crossings); end
      tests++; if (bus.period !== 16'd0) begin fails++; $display("FAIL reset_period got %0d exp 0", bus.period); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_square(input bit tog, input int exp_done);
      int d; bit bd; bit bf;
      run_meas(0, tog, tog, 0, d, bd, bf);
      tests++; if (bf !== 1'b1) begin fails++; $display("FAIL sq_busy_rise tog=%0b got %0b exp 1", tog, bf); end
      tests++; if (d != exp_done) begin fails++; $display("FAIL sq_done_at tog=%0b got %0d exp %0d", tog, d, exp_done); end
      tests++; if (bd !== 1'b1) begin fails++; $display("FAIL sq_busy_done tog=%0b got %0b exp 1", tog, bd); end
      tests++; if (bus.min_val !== 8'h00) begin fails++; $display("FAIL sq_min tog=%0b got %h exp 00", tog, bus.min_val); end
      tests++; if (bus.max_val !== 8'hFF) begin fails++; $display("FAIL sq_max tog=%0b got %h exp ff", tog, bus.max_val); end
      tests++; if (bus.p2p !== 8'hFF) begin fails++; $display("FAIL sq_p2p tog=%0b got %h exp ff", tog, bus.p2p); end
      tests++; if (bus.crossings !== 8'd2) begin fails++; $display("FAIL sq_cross tog=%0b got %0d exp 2", tog, bus.crossings); end
      tests++; if (bus.period !== 16'd128) begin fails++; $display("FAIL sq_period tog=%0b got %0d exp 128", tog, bus.period); end
      @(posedge clk); #1;
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL sq_done_pulse tog=%0b got %0b exp 0", tog, bus.done); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL sq_busy_fall tog=%0b got %0b exp 0", tog, bus.busy); end
      repeat (3) @(posedge clk);
      #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL sq_no_queue tog=%0b got %0b exp 0", tog, bus.busy); end
      tests++; if (bus.crossings !== 8'd2) begin fails++; $display("FAIL sq_hold tog=%0b got %0d exp 2", tog, bus.crossings); end
   endtask

   task automatic test_sawtooth;
      int d; bit bd; bit bf;
      run_meas(1, 1'b0, 1'b0, 0, d, bd, bf);
      tests++; if (d != 513) begin fails++; $display("FAIL saw_done_at got %0d exp 513", d); end
      tests++; if (bus.p2p !== 8'hFF) begin fails++; $display("FAIL saw_p2p got %h exp ff", bus.p2p); end
      tests++; if (bus.crossings !== 8'd1) begin fails++; $display("FAIL saw_cross got %0d exp 1", bus.crossings); end
      tests++; if (bus.period !== 16'd0) begin fails++; $display("FAIL saw_period got %0d exp 0", bus.period); end
      @(posedge clk); #1;
   endtask

   task automatic test_constant;
      int d; bit bd; bit bf;
      run_meas(2, 1'b0, 1'b0, 0, d, bd, bf);
      tests++; if (d != 513) begin fails++; $display("FAIL const_done_at got %0d exp 513", d); end
      tests++; if (bus.min_val !== 8'h80) begin fails++; $display("FAIL const_min got %h exp 80", bus.min_val); end
      tests++; if (bus.max_val !== 8'h80) begin fails++; $display("FAIL const_max got %h exp 80", bus.max_val); end
      tests++; if (bus.p2p !== 8'h00) begin fails++; $display("FAIL const_p2p got %h exp 00", bus.p2p); end
      tests++; if (bus.crossings !== 8'd0) begin fails++; $display("FAIL const_cross got %0d exp 0", bus.crossings); end
      tests++; if (bus.period !== 16'd0) begin fails++; $display("FAIL const_period got %0d exp 0", bus.period); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort_restart;
      int d; bit bd; bit bf;
      run_meas(1, 1'b0, 1'b0, 300, d, bd, bf);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b exp 0", bus.busy); end
      tests++; if (bus.max_val !== 8'h00) begin fails++; $display("FAIL abort_max got %h exp 00", bus.max_val); end
      tests++; if (bus.p2p !== 8'h00) begin fails++; $display("FAIL abort_p2p got %h exp 00", bus.p2p); end
      tests++; if (bus.crossings !== 8'd0) begin fails++; $display("FAIL abort_cross got %0d exp 0", bus.crossings); end
      tests++; if (bus.period !== 16'd0) begin fails++; $display("FAIL abort_period got %0d exp 0", bus.period); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_meas(1, 1'b0, 1'b0, 0, d, bd, bf);
      tests++; if (d != 513) begin fails++; $display("FAIL restart_done_at got %0d exp 513", d); end
      tests++; if (bus.min_val !== 8'h00) begin fails++; $display("FAIL restart_min got %h exp 00", bus.min_val); end
      tests++; if (bus.max_val !== 8'hFF) begin fails++; $display("FAIL restart_max got %h exp ff", bus.max_val); end
      tests++; if (bus.crossings !== 8'd1) begin fails++; $display("FAIL restart_cross got %0d exp 1", bus.crossings); end
      tests++; if (bus.period !== 16'd0) begin fails++; $display("FAIL restart_period got %0d exp 0", bus.period); end
      @(posedge clk); #1;
   endtask

   task automatic test_hysteresis;
      int d; bit bd; bit bf;
      logic [7:0]  exp_cross;
      logic [15:0] exp_per;
`ifdef WAVE_HYST_EN
      exp_cross = 8'd0;
      exp_per   = 16'd0;
`else
      exp_cross = 8'd128;
      exp_per   = 16'd2;
`endif
      run_meas(3, 1'b0, 1'b0, 0, d, bd, bf);
      tests++; if (d != 513) begin fails++; $display("FAIL hyst_done_at got %0d exp 513", d); end
      tests++; if (bus.p2p !== 8'hFF) begin fails++; $display("FAIL hyst_p2p got %h exp ff", bus.p2p); end
      tests++; if (bus.crossings !== exp_cross) begin fails++; $display("FAIL hyst_cross got %0d exp %0d", bus.crossings, exp_cross); end
      tests++; if (bus.period !== exp_per) begin fails++; $display("FAIL hyst_period got %0d exp %0d", bus.period, exp_per); end
      @(posedge clk); #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_square(1'b0, 513);
      test_sawtooth();
      test_constant();
      test_square(1'b1, 1025);
      test_abort_restart();
      test_hysteresis();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wave_analyzer.md
# wave_analyzer

Measurement block at the receive end of the waveform sample stream. It consumes the 8-bit samples produced by the waveform generator and runs two windowed passes over them. The first pass captures the minimum and maximum. The second pass counts rising midpoint crossings and measures the period between them. Results are held in registers, and `done` pulses when they are valid, for the display/readback logic.

## Interface
- `WIN_LOG2`, default 8: window length N = 2^WIN_LOG2 valid samples per pass.
- `CNT_W`, default 16: width of the period counter.
- `HYST`, default 4: hysteresis margin in LSBs. Used only when `WAVE_HYST_EN` is defined.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a measurement. Sampled only in IDLE.
- `sample_valid`, in, 1: `sample` is valid this cycle.
- `sample`, in, 8: unsigned waveform sample.
- `busy`, out, 1: high in MINMAX, PERIOD and DONE.
- `done`, out, 1: one-cycle pulse; result outputs update in the same cycle.
- `min_val`, out, 8: minimum sample in pass 1.
- `max_val`, out, 8: maximum sample in pass 1.
- `p2p`, out, 8: `max_val - min_val`.
- `crossings`, out, 8: rising crossings in pass 2, saturating at 255.
- `period`, out, CNT_W: valid samples between the last two rising crossings. 0 if fewer than 2 crossings occurred.

## Operation
- States and transitions:
  - IDLE → MINMAX on `start`.
  - MINMAX → PERIOD after N valid samples.
  - PERIOD → DONE after N valid samples.
  - DONE → IDLE unconditionally.
- MINMAX:
  - Running min initialises to 0xFF and running max to 0x00.
  - They update only on `sample_valid`.
  - The sample counter is WIN_LOG2+1 bits wide and is cleared on every state change.
- PERIOD entry: `mid = (min + max) >> 1`, computed 9 bits wide and truncated to 8 bits.
- Rising crossing: a valid sample with `prev < mid && sample >= mid`.
  - `prev` is the previous valid sample within the current pass.
  - The first valid sample of PERIOD never counts as a crossing.
- Period counter:
  - Increments on each valid sample after the first crossing, saturating at all ones.
  - On each later crossing: `period_r <= count + 1`, then `count <= 0`.
- DONE: registers all result outputs, pulses `done`, and updates `p2p`.
- Samples with `sample_valid` low are ignored in every state; the passes stall.
- `start` asserted while `busy` is ignored; it is not queued.
- Results hold their values until the next DONE.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `min_val`, `max_val`, `p2p`, `crossings` and `period` all 0.
- Reset mid-measurement aborts to IDLE and zeros all outputs.
- With `sample_valid` held high:
  - `start` is sampled at edge k.
  - The first MINMAX sample is taken at edge k+1.
  - `done` is high for the single cycle following edge k+2N+1.
  - `busy` rises after edge k and falls after edge k+2N+2.
- Each invalid cycle during a pass delays `done` by exactly one cycle.
- The crossing decision uses registered `prev`. There is no extra pipeline latency; results appear only in DONE.

## Configuration
- `WAVE_HYST_EN` defined:
  - The crossing detector is armed when a valid sample satisfies `sample < mid - HYST`.
  - A crossing fires when armed and `sample >= mid + HYST`; firing disarms the detector.
  - Both thresholds are computed 9 bits wide and clamped to 0..255.
- `WAVE_HYST_EN` undefined: plain comparison as described under Operation; `HYST` is unused.

## Structure
- Package `wave_pkg` holds:
  - `SAMPLE_W = 8`.
  - The state enum `wa_state_t` (IDLE, MINMAX, PERIOD, DONE).
  - The saturation helper constants.
- One sub-module, `wave_cross_det`. It contains `prev` and arm registers plus the crossing comparator, and has the `WAVE_HYST_EN` logic isolated inside it.
- The top level contains the FSM, the counters, min/max and the result registers.

## Test plan
- N=256; repeating pattern of 64×0x00 then 64×0xFF; valid held high → `min_val`=0x00, `max_val`=0xFF, `p2p`=0xFF, `crossings`=2, `period`=128, `done` 513 cycles after the `start` edge.
- Sawtooth 0x00..0xFF repeating → `crossings`=1, `period`=0 (fewer than 2 crossings), `p2p`=255.
- Constant 0x80 → `min_val`=`max_val`=0x80, `p2p`=0, `crossings`=0, `period`=0.
- Square-wave stimulus with `sample_valid` toggling every cycle → results identical to the first scenario; `done` at edge k+1025; `start` pulses during `busy` have no effect.
- Assert `rst` during PERIOD, then restart with the sawtooth → all outputs read 0 immediately after reset; the next `done` reports sawtooth results only.
- With `WAVE_HYST_EN` and HYST=4, after a 0x00/0xFF window:
  - Stimulus alternating 0x7E/0x81 every sample, mid=0x7F → `crossings`=0.
  - Same stimulus without the macro → `crossings`=128, `period`=2.
